ntt_lane_dma: RTL and testbench
===============================

NTT_LANE_DMA -- requirements
Module: ntt_lane_dma

Interface
REQ-001 Parameter: LANE, default 8, 32-bit words per vector beat; must match the shared package value.
REQ-002 Parameter: NBEATS, default 64, beats per transform; N = LANE*NBEATS = 512 words.
REQ-003 Parameter: AW, default 14, word-address width of memory port B.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a transform; ignored while busy=1.
REQ-007 src_base  in  AW  word address of the first input word; sampled when start is accepted.
REQ-008 dst_base  in  AW  word address of the first result word; sampled when start is accepted.
REQ-009 busy  out  1  high from the cycle after start is accepted until done.
REQ-010 done  out  1  one-cycle pulse after the final result write is issued.
REQ-011 renb  out  1  port-B read enable.
REQ-012 wenb  out  1  port-B write enable.
REQ-013 webb  out  4  port-B byte enables; 4'hF whenever wenb=1, otherwise 0.
REQ-014 w_is_vector  out  1  equals wenb; vector-wide write.
REQ-015 addrb  out  AW  port-B word address.
REQ-016 datab  out  type_vector  write vector.
REQ-017 qb  in  type_vector  read vector, valid one cycle after renb.
REQ-018 ntt_valid  out  1  beat valid toward NTT.
REQ-019 ntt_data  out  type_vector  beat data toward NTT.
REQ-020 res_valid  in  1  NTT result beat valid; no backpressure.
REQ-021 res_data  in  type_vector  NTT result beat.

Function
REQ-022 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-023 IDLE->RUN on start: latch src_base and dst_base; clear rd_cnt and wr_cnt.
REQ-024 RUN, res_valid=0, rd_cnt<NBEATS: renb=1, addrb=src+LANE*rd_cnt, rd_cnt++.
REQ-025 Any state except IDLE, res_valid=1: wenb=1, addrb=dst+LANE*wr_cnt, datab=res_data, wr_cnt++; the write has priority and no read issues that cycle.
REQ-026 Read latency 1: a renb in cycle t drives ntt_valid=1 and ntt_data=qb in cycle t+1; ntt_valid is registered off renb.
REQ-027 ntt_valid may drop between beats when a read is stalled by a write; the NTT tolerates gaps.
REQ-028 RUN->DRAIN when rd_cnt reaches NBEATS.
REQ-029 DRAIN->DONE on the cycle wr_cnt reaches NBEATS.
REQ-030 DONE: done=1 for one cycle, then IDLE.
REQ-031 res_valid while in IDLE is dropped and does not change wr_cnt.
REQ-032 res_valid beats beyond NBEATS in a transform are dropped.
REQ-033 Address arithmetic is modulo 2^AW; wrap past the top of memory is permitted.
REQ-034 rd_cnt and wr_cnt are clog2(NBEATS)+1 bits wide.
REQ-035 start coinciding with done is ignored.

Reset
REQ-036 While rst=1: state=IDLE; counters=0.
REQ-037 While rst=1, all outputs are 0: busy, done, renb, wenb, webb, w_is_vector, addrb, datab, ntt_valid, ntt_data.
REQ-038 rst mid-transform aborts immediately; no further port-B access occurs; the partial transform is not resumed.

Structure
REQ-039 LANE, NBEATS and type_vector (LANE x 32-bit array) belong in the shared package used by the memory and the NTT.
REQ-040 One sub-module, ntt_dma_addr_gen: base register plus beat counter producing base+LANE*cnt; instantiated once for reads and once for writes.

Verification
REQ-041 Scenario: memory preloaded with word value = word index; start with src=0, dst=1024; NTT model echoes after 10 cycles -> words 1024..1535 equal 0..511; done pulses once; busy falls the cycle after done.
REQ-042 Scenario: result beat arrives while reads remain -> no cycle has renb=1 and wenb=1; ntt_data sequence has no missing or duplicated beats.
REQ-043 Scenario: src = 2^AW-256 -> read addresses wrap to 0..255 after the top of memory.
REQ-044 Scenario: start pulsed while busy, and again at done -> both ignored; exactly 64 reads and 64 writes.
REQ-045 Scenario: rst asserted at beat 30 -> renb=0 and wenb=0 next cycle; no done; a new start afterwards completes normally.
REQ-046 Scenario: res_valid in IDLE, and 65 result beats in one transform -> no writes in IDLE; the 65th beat is dropped.

Source files
------------

// File: rtl/ntt_lane_dma_pkg.sv
// Shared lane geometry, vector type and DMA state encoding for the
// NTT lane DMA, the vector memory and the NTT core.
package ntt_lane_dma_pkg;

    localparam int LANE   = 8;
    localparam int NBEATS = 64;
    localparam int AW     = 14;

    typedef logic [LANE-1:0][31:0] type_vector;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } dma_state_e;

endpackage

// File: rtl/ntt_dma_addr_gen.sv
// Base register plus beat counter; produces base + LANE*cnt modulo 2^AW.
module ntt_dma_addr_gen #(
    parameter int LANE = 8,
    parameter int AW   = 14,
    parameter int CW   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] base,
    output logic [AW-1:0] addr,
    output logic [CW-1:0] cnt
);

    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        if (load) begin
            base_d = base;
            cnt_d  = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end

    // Truncation to AW bits gives the wrap past the top of memory.
    assign addr = base_q + AW'(cnt_q) * AW'(LANE);
    assign cnt  = cnt_q;

endmodule

// File: rtl/ntt_lane_dma.sv
// Streams NBEATS vectors from port B into the NTT and writes the result
// beats back; result writes always win the port over pending reads.
module ntt_lane_dma
    import ntt_lane_dma_pkg::type_vector;
    import ntt_lane_dma_pkg::dma_state_e;
    import ntt_lane_dma_pkg::S_IDLE;
    import ntt_lane_dma_pkg::S_RUN;
    import ntt_lane_dma_pkg::S_DRAIN;
    import ntt_lane_dma_pkg::S_DONE;
#(
    parameter int LANE   = ntt_lane_dma_pkg::LANE,
    parameter int NBEATS = ntt_lane_dma_pkg::NBEATS,
    parameter int AW     = ntt_lane_dma_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    output logic          busy,
    output logic          done,
    output logic          renb,
    output logic          wenb,
    output logic [3:0]    webb,
    output logic          w_is_vector,
    output logic [AW-1:0] addrb,
    output type_vector    datab,
    input  type_vector    qb,
    output logic          ntt_valid,
    output type_vector    ntt_data,
    input  logic          res_valid,
    input  type_vector    res_data
);

    localparam int CW = $clog2(NBEATS) + 1;
    localparam logic [CW-1:0] NB = CW'(NBEATS);

    dma_state_e    state_q, state_d;
    logic          ntt_valid_q, ntt_valid_d;
    logic          load, rd_inc, wr_inc;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [CW-1:0] rd_cnt, wr_cnt;

    ntt_dma_addr_gen #(.LANE(LANE), .AW(AW), .CW(CW)) u_rd_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .inc  (rd_inc),
        .base (src_base),
        .addr (rd_addr),
        .cnt  (rd_cnt)
    );

    ntt_dma_addr_gen #(.LANE(LANE), .AW(AW), .CW(CW)) u_wr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .inc  (wr_inc),
        .base (dst_base),
        .addr (wr_addr),
        .cnt  (wr_cnt)
    );

    always_comb begin
        state_d = state_q;
        renb    = 1'b0;
        wenb    = 1'b0;
        addrb   = '0;
        datab   = '0;
        rd_inc  = 1'b0;
        wr_inc  = 1'b0;
        load    = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);

        // Beats past NBEATS are dropped so they cannot stall reads.
        if (state_q != S_IDLE && res_valid && wr_cnt < NB) begin
            wenb   = 1'b1;
            addrb  = wr_addr;
            datab  = res_data;
            wr_inc = 1'b1;
        end else if (state_q == S_RUN && rd_cnt < NB) begin
            renb   = 1'b1;
            addrb  = rd_addr;
            rd_inc = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rd_cnt + CW'(rd_inc) == NB) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wr_cnt + CW'(wr_inc) == NB) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ntt_valid_d = renb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ntt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ntt_valid_q <= ntt_valid_d;
        end
    end

    assign webb        = wenb ? 4'hF : 4'h0;
    assign w_is_vector = wenb;
    assign ntt_valid   = ntt_valid_q;
    assign ntt_data    = ntt_valid_q ? qb : '0;

endmodule

// File: tb/tb_ntt_lane_dma.sv
// Self-checking bench: vector memory, echoing NTT model and a
// transaction-level reference of the read/write address streams.
module tb_ntt_lane_dma;
    import ntt_lane_dma_pkg::type_vector;

    localparam int LANE  = 8;
    localparam int NB    = 64;
    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_base, dst_base;
    logic          busy, done, renb, wenb, w_is_vector, ntt_valid, res_valid;
    logic [3:0]    webb;
    logic [AW-1:0] addrb;
    type_vector    datab, qb, ntt_data, res_data;

    ntt_lane_dma #(.LANE(LANE), .NBEATS(NB), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .busy        (busy),
        .done        (done),
        .renb        (renb),
        .wenb        (wenb),
        .webb        (webb),
        .w_is_vector (w_is_vector),
        .addrb       (addrb),
        .datab       (datab),
        .qb          (qb),
        .ntt_valid   (ntt_valid),
        .ntt_data    (ntt_data),
        .res_valid   (res_valid),
        .res_data    (res_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [31:0] mem [DEPTH];

    always @(posedge clk) begin
        if (wenb)
            for (int i = 0; i < LANE; i++) mem[(int'(addrb) + i) % DEPTH] = datab[i];
        if (renb)
            for (int i = 0; i < LANE; i++) qb[i] <= mem[(int'(addrb) + i) % DEPTH];
    end

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    endtask

    // Reference state for the transform in flight.
    int  m_src, m_dst, rd_seen, wr_seen, nv_seen, done_cnt, acc_cyc, echo_dly;
    bit  m_active = 1'b0;
    int  rd_log [NB];

    typedef struct {
        int         due;
        type_vector d;
    } echo_t;
    echo_t eq[$];

    int  inj_idle = 0;
    bit  inj_done = 1'b0;

    function automatic type_vector beat_of(input int src, input int k);
        type_vector v;
        for (int i = 0; i < LANE; i++) v[i] = 32'((src + LANE * k + i) % DEPTH);
        return v;
    endfunction

    function automatic type_vector rand_vec();
        type_vector v;
        for (int i = 0; i < LANE; i++) v[i] = $urandom;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ctrl", {busy, done, renb, wenb, webb, w_is_vector, ntt_valid}, '0);
            chk("rst_addrb", addrb, '0);
            chk("rst_datab", datab, '0);
            chk("rst_ntt_data", ntt_data, '0);
        end else begin
            chk("rw_exclusive", renb & wenb, '0);
            chk("webb", webb, wenb ? 4'hF : 4'h0);
            chk("w_is_vector", w_is_vector, wenb);
            chk("busy", busy, m_active && cyc != acc_cyc);
            if (!m_active) chk("idle_quiet", {renb, wenb, done, ntt_valid}, '0);
            if (renb) begin
                chk("rd_addr", addrb, (m_src + LANE * rd_seen) % DEPTH);
                if (rd_seen < NB) rd_log[rd_seen] = int'(addrb);
                rd_seen++;
            end
            if (wenb) begin
                chk("wr_addr", addrb, (m_dst + LANE * wr_seen) % DEPTH);
                chk("wr_data", datab, res_data);
                wr_seen++;
            end
            if (ntt_valid) begin
                chk("ntt_data", ntt_data, beat_of(m_src, nv_seen));
                nv_seen++;
                eq.push_back('{cyc + (echo_dly > 0 ? echo_dly : int'($urandom_range(20, 2))),
                               ntt_data});
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last_write", wr_seen, NB);
                m_active = 1'b0;
            end
        end
    end

    // NTT model: echoes each beat back after its delay; extra beats on request.
    initial begin
        res_valid = 1'b0;
        res_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            res_valid = 1'b0;
            res_data  = '0;
            if (!rst) begin
                if (inj_done && done) begin
                    res_valid = 1'b1;
                    res_data  = rand_vec();
                    inj_done  = 1'b0;
                end else if (inj_idle > 0) begin
                    res_valid = 1'b1;
                    res_data  = rand_vec();
                    inj_idle--;
                end else if (eq.size() > 0 && eq[0].due <= cyc) begin
                    res_valid = 1'b1;
                    res_data  = eq.pop_front().d;
                end
            end
        end
    end

    task automatic run(input int src, input int dst, input int dly,
                       input bit s_busy, input bit s_done, input bit x_done,
                       input int rst_at);
        bit finished = 1'b0;
        bit aborted  = 1'b0;
        int errs     = 0;
        preload();
        m_src    = src;
        m_dst    = dst;
        rd_seen  = 0;
        wr_seen  = 0;
        nv_seen  = 0;
        done_cnt = 0;
        echo_dly = dly;
        eq.delete();
        @(posedge clk);
        #1;
        src_base = AW'(src);
        dst_base = AW'(dst);
        start    = 1'b1;
        m_active = 1'b1;
        acc_cyc  = cyc;
        inj_done = x_done;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_base = AW'($urandom);
        dst_base = AW'($urandom);
        for (int n = 0; n < 3000 && !finished && !aborted; n++) begin
            start = (s_busy && n == 20);
            if (rst_at >= 0 && rd_seen == rst_at) begin
                rst      = 1'b1;
                m_active = 1'b0;
                eq.delete();
                aborted  = 1'b1;
            end else if (done) begin
                start    = s_done;
                finished = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (aborted) begin
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, 0);
            chk("abort_reads", rd_seen, rst_at);
        end else begin
            chk("transform_finished", finished, 1'b1);
            repeat (20) @(posedge clk);
            #1;
            inj_done = 1'b0;
            chk("read_count", rd_seen, NB);
            chk("write_count", wr_seen, NB);
            chk("ntt_beat_count", nv_seen, NB);
            chk("done_count", done_cnt, 1);
            for (int j = 0; j < NB * LANE; j++)
                if (mem[(dst + j) % DEPTH] != 32'((src + j) % DEPTH)) errs++;
            chk("mem_result", errs, 0);
        end
    endtask

    initial begin
        int s, d;
        rst      = 1'b1;
        start    = 1'b0;
        src_base = '0;
        dst_base = '0;
        preload();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(0, 1024, 10, 1'b0, 1'b0, 1'b0, -1);
        chk("lit_mem1024", mem[1024], 32'd0);
        chk("lit_mem1100", mem[1100], 32'd76);
        chk("lit_mem1535", mem[1535], 32'd511);
        chk("lit_mem1536_untouched", mem[1536], 32'd1536);

        run(DEPTH - 256, 4096, 0, 1'b0, 1'b0, 1'b0, -1);
        chk("lit_wrap_rd0", rd_log[0], 16128);
        chk("lit_wrap_rd31", rd_log[31], 16376);
        chk("lit_wrap_rd32", rd_log[32], 0);
        chk("lit_wrap_rd63", rd_log[63], 248);

        inj_idle = 4;
        repeat (8) @(posedge clk);
        #1;
        chk("idle_beats_dropped", wr_seen, NB);
        s = int'($urandom_range(DEPTH - 1, 0));
        d = (s + 512 + int'($urandom_range(DEPTH - 1024, 0))) % DEPTH;
        run(s, d, 0, 1'b1, 1'b1, 1'b1, -1);

        s = int'($urandom_range(DEPTH - 1, 0));
        d = (s + 2048) % DEPTH;
        run(s, d, 0, 1'b0, 1'b0, 1'b0, 30);

        run(0, 1024, 0, 1'b0, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
